// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared definitions for the instruction encoder / program loader:
//   - opcode constants of the 16-bit custom processor
//   - bit positions of every instruction field inside the 16-bit word
//   - loader FSM state encoding
//   - packed struct carrying one field-level instruction description
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

    // Opcodes with special packing rules; everything else packs as R-type.
    localparam logic [3:0] OP_SLL      = 4'd1;
    localparam logic [3:0] OP_SLR      = 4'd2;
    localparam logic [3:0] OP_ITYPE_LO = 4'd5;
    localparam logic [3:0] OP_LI       = 4'd6;
    localparam logic [3:0] OP_LW       = 4'd7;
    localparam logic [3:0] OP_SW       = 4'd8;
    localparam logic [3:0] OP_JMP      = 4'd9;
    localparam logic [3:0] OP_MUL      = 4'd10;

    // Field LSB positions inside the instruction word.
    localparam int OPC_LSB   = 0;
    localparam int RD_LSB    = 4;
    localparam int RS1_LSB   = 7;
    localparam int RS2_LSB   = 10;
    localparam int SHAMT_LSB = 13;
    localparam int IMM_LSB   = 10;
    localparam int JADDR_LSB = 4;

    // Field widths.
    localparam int OPC_W   = 4;
    localparam int REG_W   = 3;
    localparam int SHAMT_W = 3;
    localparam int IMM_W   = 6;
    localparam int JADDR_W = 8;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [SHAMT_W-1:0] shamt;
        logic [IMM_W-1:0]   imm;
        logic [JADDR_W-1:0] jaddr;
    } fields_t;

    // I-type opcodes carry a 6-bit immediate in the upper bits.
    function automatic logic is_itype(input logic [OPC_W-1:0] op);
        return (op == OP_ITYPE_LO) || (op == OP_LI) ||
               (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_shift(input logic [OPC_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SLR);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Valid/ready stream carrying one field-level instruction description.
//   in_valid  : producer has a bundle
//   in_ready  : encoder can accept a bundle
//   f_opcode, f_rd, f_rs1, f_rs2, f_shamt, f_imm, f_jaddr : instruction fields
// Modports: master (host/test loader side), slave (encoder side).
// -----------------------------------------------------------------------------
interface instr_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] f_opcode;
    logic [2:0] f_rd;
    logic [2:0] f_rs1;
    logic [2:0] f_rs2;
    logic [2:0] f_shamt;
    logic [5:0] f_imm;
    logic [7:0] f_jaddr;

    modport master (
        output in_valid, f_opcode, f_rd, f_rs1, f_rs2, f_shamt, f_imm, f_jaddr,
        input  in_ready
    );

    modport slave (
        input  in_valid, f_opcode, f_rd, f_rs1, f_rs2, f_shamt, f_imm, f_jaddr,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational golden encoder: packs one field bundle into a 16-bit
// instruction word and flags illegal opcodes.
//   i_fields  : field bundle (opcode, rd, rs1, rs2, shamt, imm, jaddr)
//   o_word    : packed 16-bit instruction
//   o_illegal : opcode outside the legal set (only when checking is enabled)
// Optional feature macro: INSTR_ENC_CHECK_EN -- when defined, opcodes above
// mul (11..15) are reported illegal; otherwise they pack as R-type.
// -----------------------------------------------------------------------------
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fields_t              i_fields,
    output logic [INSTR_W-1:0]   o_word,
    output logic                 o_illegal
);

    always_comb begin
        o_word = '0;
        o_word[OPC_LSB +: OPC_W] = i_fields.opcode;
        if (i_fields.opcode == OP_JMP) begin
            o_word[JADDR_LSB +: JADDR_W] = i_fields.jaddr;
        end else begin
            o_word[RD_LSB  +: REG_W] = i_fields.rd;
            o_word[RS1_LSB +: REG_W] = i_fields.rs1;
            if (is_itype(i_fields.opcode)) begin
                o_word[IMM_LSB +: IMM_W] = i_fields.imm;
            end else begin
                // R-type and shifts share rs2; only shifts fill the top bits.
                o_word[RS2_LSB +: REG_W] = i_fields.rs2;
                if (is_shift(i_fields.opcode)) begin
                    o_word[SHAMT_LSB +: SHAMT_W] = i_fields.shamt;
                end
            end
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    assign o_illegal = (i_fields.opcode > OP_MUL);
`else
    assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Sequential program loader: accepts field bundles over a valid/ready stream,
// packs each into the 16-bit instruction format and writes it to instruction
// memory at consecutive (wrapping) addresses.
// Parameters: ADDR_W (address width), DEPTH (words per session, <= 2^ADDR_W)
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   i_start        : begin a session at i_base_addr (honoured in IDLE only)
//   i_stop         : end the session; blocks any transfer in the same cycle
//   i_base_addr    : first write address, sampled on start
//   s_in           : field bundle stream (slave side)
//   o_imem_we      : instruction memory write strobe
//   o_imem_addr    : write address (holds when no write)
//   o_imem_wdata   : packed instruction (holds when no write)
//   o_busy         : high while loading
//   o_done         : one-cycle pulse at session end
//   o_err          : sticky illegal-opcode flag, cleared on start
//   o_count        : words written this session
// Optional feature macro: INSTR_ENC_CHECK_EN (illegal opcode detection,
// implemented in instr_pack; illegal bundles are consumed but not written).
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [ADDR_W-1:0]   i_base_addr,
    instr_encoder_if.slave      s_in,
    output logic                o_imem_we,
    output logic [ADDR_W-1:0]   o_imem_addr,
    output logic [INSTR_W-1:0]  o_imem_wdata,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [ADDR_W:0]     o_count
);

    // The session ends on the write that brings the count to DEPTH, which is
    // equivalent to targeting base_addr + DEPTH - 1 for any base address.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    state_t               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W:0]      r_count;
    logic                 r_imem_we;
    logic [ADDR_W-1:0]    r_imem_addr;
    logic [INSTR_W-1:0]   r_imem_wdata;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    fields_t              w_fields;
    logic [INSTR_W-1:0]   w_word;
    logic                 w_illegal;
    logic                 w_ready;
    logic                 w_last;

    assign w_fields.opcode = s_in.f_opcode;
    assign w_fields.rd     = s_in.f_rd;
    assign w_fields.rs1    = s_in.f_rs1;
    assign w_fields.rs2    = s_in.f_rs2;
    assign w_fields.shamt  = s_in.f_shamt;
    assign w_fields.imm    = s_in.f_imm;
    assign w_fields.jaddr  = s_in.f_jaddr;

    instr_pack u_pack (
        .i_fields  (w_fields),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // stop has priority over a transfer, so it gates ready combinationally.
    assign w_ready       = (r_state == ST_RUN) && !i_stop;
    assign s_in.in_ready = w_ready;
    assign w_last        = (r_count == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_count      <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_addr  <= i_base_addr;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end else if (s_in.in_valid) begin
                        if (w_illegal) begin
                            // Consumed but not written; address and count hold.
                            r_err <= 1'b1;
                        end else begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_addr;
                            r_imem_wdata <= w_word;
                            r_addr       <= r_addr + 1'b1;
                            r_count      <= r_count + 1'b1;
                            if (w_last) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    // Pulse lands one cycle after the final write strobe.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_count      = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Randomized, scoreboard-based bench for instr_encoder. Expected writes are
// queued by the stimulus side from a field-arithmetic reference model and
// popped by an independent monitor on every write strobe.
// Honours INSTR_ENC_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
`ifdef INSTR_ENC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_stop = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [15:0]       o_imem_wdata;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [ADDR_W:0]   o_count;

    instr_encoder_if bus();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_base_addr  (i_base_addr),
        .s_in         (bus.slave),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic [ADDR_W:0]   cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    bit                m_run = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [ADDR_W:0]   m_count = '0;
    logic              m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction format expressed as weighted field sums.
    function automatic logic [15:0] ref_pack(input int op, input int rd, input int rs1,
                                             input int rs2, input int sh, input int imm,
                                             input int ja);
        int w;
        if (op == 9)
            w = ja * 16 + op;
        else if (op >= 5 && op <= 8)
            w = imm * 1024 + rs1 * 128 + rd * 16 + op;
        else if (op == 1 || op == 2)
            w = sh * 8192 + rs2 * 1024 + rs1 * 128 + rd * 16 + op;
        else
            w = rs2 * 1024 + rs1 * 128 + rd * 16 + op;
        return w[15:0];
    endfunction

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_imem_we === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("imem_addr",  32'(o_imem_addr),  32'(mon_e.addr));
                check("imem_wdata", 32'(o_imem_wdata), 32'(mon_e.data));
                check("count",      32'(o_count),      32'(mon_e.cnt));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_imem_we"},  32'(o_imem_we),    32'd0);
        check({tag, "_addr"},     32'(o_imem_addr),  32'd0);
        check({tag, "_wdata"},    32'(o_imem_wdata), 32'd0);
        check({tag, "_busy"},     32'(o_busy),       32'd0);
        check({tag, "_done"},     32'(o_done),       32'd0);
        check({tag, "_err"},      32'(o_err),        32'd0);
        check({tag, "_count"},    32'(o_count),      32'd0);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        i_base_addr = b;
        i_start = 1'b1;
        sync();
        i_start = 1'b0;
        m_run = 1'b1;
        m_addr = b;
        m_count = '0;
        m_err = 1'b0;
        check("start_busy",  32'(o_busy),  32'd1);
        check("start_err",   32'(o_err),   32'd0);
        check("start_count", 32'(o_count), 32'd0);
    endtask

    // Present one bundle for one cycle; the model decides whether it is taken.
    task automatic xfer(input int op, input int rd, input int rs1, input int rs2,
                        input int sh, input int imm, input int ja);
        bus.f_opcode = op[3:0];
        bus.f_rd     = rd[2:0];
        bus.f_rs1    = rs1[2:0];
        bus.f_rs2    = rs2[2:0];
        bus.f_shamt  = sh[2:0];
        bus.f_imm    = imm[5:0];
        bus.f_jaddr  = ja[7:0];
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("in_ready", 32'(bus.in_ready), 32'(m_run && !i_stop));
        if (m_run && !i_stop) begin
            if (CHK && op >= 11) begin
                m_err = 1'b1;
            end else begin
                m_count = m_count + 1'b1;
                q.push_back('{m_addr, ref_pack(op, rd, rs1, rs2, sh, imm, ja), m_count});
                m_addr = m_addr + 1'b1;
                if (m_count == DEPTH) m_run = 1'b0;
            end
        end
        sync();
        bus.in_valid = 1'b0;
    endtask

    task automatic rand_xfer();
        xfer($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63),
             $urandom_range(0, 255));
    endtask

    task automatic do_stop();
        i_stop = 1'b1;
        bus.f_opcode = 4'd0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("stop_in_ready", 32'(bus.in_ready), 32'd0);
        sync();
        i_stop = 1'b0;
        bus.in_valid = 1'b0;
        m_run = 1'b0;
    endtask

    task automatic wait_done();
        int seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                seen++;
                check("done_after_write", 32'(o_imem_we), 32'd0);
            end
        end
        check("done_pulses", 32'(seen), 32'd1);
        check("end_busy", 32'(o_busy), 32'd0);
        check("end_in_ready", 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.f_opcode = '0; bus.f_rd = '0; bus.f_rs1 = '0; bus.f_rs2 = '0;
        bus.f_shamt = '0;  bus.f_imm = '0; bus.f_jaddr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        sync();

        // Directed packing cases
        do_start(8'h10);
        xfer(0, 3, 1, 2, 0, 0, 0);
        @(negedge clk);
        check("add_we",    32'(o_imem_we),    32'd1);
        check("add_addr",  32'(o_imem_addr),  32'h10);
        check("add_wdata", 32'(o_imem_wdata), 32'h08B0);
        check("add_count", 32'(o_count),      32'd1);
        sync();
        xfer(9, 0, 0, 0, 0, 0, 8'hA5);
        @(negedge clk);
        check("jmp_wdata", 32'(o_imem_wdata), 32'h0A59);
        sync();
        xfer(7, 2, 4, 0, 0, 6'h2A, 0);
        @(negedge clk);
        check("lw_wdata", 32'(o_imem_wdata), 32'hAA27);
        sync();
        xfer(1, 1, 2, 0, 5, 0, 0);
        @(negedge clk);
        check("sll_wdata", 32'(o_imem_wdata), 32'hA111);
        sync();

        // Back-to-back random bundles
        for (int i = 0; i < 4; i++) rand_xfer();

        // Opcode 12 between two legal bundles
        xfer(3, 1, 1, 1, 0, 0, 0);
        xfer(12, 2, 3, 4, 1, 5, 6);
        xfer(4, 5, 6, 7, 0, 0, 0);
        check("err_after_op12", 32'(o_err), 32'(m_err));

        do_stop();
        wait_done();
        check("err_sticky", 32'(o_err), 32'(m_err));

        // Full wrapping session from 0xFE
        do_start(8'hFE);
        for (int i = 0; i < 600 && m_run; i++) begin
            if ($urandom_range(0, 7) == 0) sync();
            rand_xfer();
        end
        wait_done();
        check("full_count", 32'(o_count), 32'(DEPTH));
        rand_xfer();

        // Asynchronous reset mid-stream
        do_start(8'($urandom_range(0, 255)));
        for (int i = 0; i < 5; i++) rand_xfer();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        q.delete();
        m_run = 1'b0;
        #10;
        rst_n = 1'b1;
        sync();

        // Recovery session ended by stop
        do_start(8'h40);
        for (int i = 0; i < 3; i++) rand_xfer();
        do_stop();
        wait_done();

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential program loader for the 16-bit custom processor. Accepts field-level instruction descriptions (opcode, registers, immediate, shift amount, jump target) over a valid/ready stream, packs each into the processor's 16-bit instruction format, and writes it into instruction memory at consecutive addresses. It is the inverse of the core's instruction decode stage and sits between the host/test loader and the instruction memory write port.

## Interface
- ADDR_W, 8: instruction memory address width; matches the 8-bit jump address.
- DEPTH, 256: number of writable words; must satisfy DEPTH ≤ 2^ADDR_W.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load session at base_addr; honoured only in IDLE.
- stop  in  1  end the session after any in-flight write.
- base_addr  in  ADDR_W  first write address, sampled on start.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- f_opcode  in  4  opcode.
- f_rd  in  3  destination register.
- f_rs1  in  3  source-1 register.
- f_rs2  in  3  source-2 register.
- f_shamt  in  3  shift amount (sll/slr).
- f_imm  in  6  immediate (I-type).
- f_jaddr  in  8  jump target.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  packed instruction.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky illegal-opcode flag, cleared on start.
- count  out  ADDR_W+1  words written this session.

## Operation
- States: IDLE, RUN, DONE. IDLE→RUN on start (addr←base_addr, count←0, err←0). RUN→DONE on stop, or on accepting the bundle that targets the last address. DONE→IDLE unconditionally after one cycle.
- in_ready = (state==RUN) && !stop. Transfer occurs when in_valid && in_ready.
- Packing: bits[3:0]=opcode always. Opcode 9 (jump): [11:4]=jaddr, [15:12]=0. Opcodes 5–8 (I-type): [6:4]=rd, [9:7]=rs1, [15:10]=imm. Opcodes 1–2 (sll/slr): [6:4]=rd, [9:7]=rs1, [12:10]=rs2, [15:13]=shamt. All others (R-type, incl. mul=10): [6:4]=rd, [9:7]=rs1, [12:10]=rs2, [15:13]=0.
- Last address = base_addr + DEPTH − 1 modulo 2^ADDR_W; addr wraps modulo 2^ADDR_W. If base_addr ≠ 0, the session still ends after exactly DEPTH words.
- start while in RUN or DONE is ignored. stop and a transfer in the same cycle: in_ready is low, so no transfer; go to DONE.
- Reset mid-session: all state cleared immediately; no partial write is emitted.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, count=0, state IDLE.
- Latency: transfer at edge N → imem_we=1 with addr/wdata during cycle N+1 (registered outputs). Throughput one word per cycle.
- count increments together with imem_we; the DONE pulse follows the last imem_we by one cycle at the earliest.
- imem_addr/imem_wdata hold their last values when imem_we=0.

## Configuration
- INSTR_ENC_CHECK_EN defined: opcodes 11–15 are illegal; the bundle is consumed, not written, count/addr unchanged, err set.
- Undefined: opcodes 11–15 packed as R-type and written normally; err stays 0.

## Structure
- Shared package: opcode constants (OP_SLL=1, OP_SLR=2, OP_LI=6, OP_LW=7, OP_SW=8, OP_JMP=9, OP_MUL=10, I-type range 5–8), field bit positions, state enum.
- One combinational sub-module, instr_pack: fields in, 16-bit word out, plus illegal flag; shared with the decode testbench as the golden encoder.

## Test plan
- Reset, start base_addr=0x10, one bundle add rd=3 rs1=1 rs2=2 → imem_we at addr 0x10, wdata=0x08B0, count=1.
- Jump opcode 9, jaddr=0xA5 → wdata=0x0A59; I-type lw rd=2 rs1=4 imm=0x2A → wdata=0xAA27.
- sll rd=1 rs1=2 rs2=0 shamt=5 → wdata=0xA111; back-to-back 4 bundles → 4 consecutive imem_we cycles, addresses +1 each.
- base_addr=0xFE, stream DEPTH words → addr wraps 0xFF→0x00, session ends after 256 writes, done pulses, in_ready drops.
- With INSTR_ENC_CHECK_EN, opcode 12 between two legal bundles → only 2 writes, contiguous addresses, err=1 until next start.
- Assert rst_n low mid-stream → all outputs at reset values asynchronously; stop during RUN with in_valid high → no transfer, done pulse next cycle.
